// File: rtl/wb_accel_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single accelerator slave.
// Define ARB_TIMEOUT_EN to add the slave-ack watchdog; otherwise stalls are unbounded.
module wb_accel_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, REL} state_t;

  state_t state_reg, state_next;
  logic   last_m1_reg, last_m1_next;
  logic   req0, req1;
  logic   to_hit;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_accel_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_reg   <= IDLE;
      last_m1_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      last_m1_reg <= last_m1_next;
    end
  end

  // On a tie the master that did not win last time gets the bus.
  always_comb begin
    state_next   = state_reg;
    last_m1_next = last_m1_reg;
    case (state_reg)
      IDLE: begin
        if (req0 && (!req1 || last_m1_reg)) begin
          state_next   = OWN0;
          last_m1_next = 1'b0;
        end else if (req1) begin
          state_next   = OWN1;
          last_m1_next = 1'b1;
        end
      end
      OWN0:    if (!m0_cyc_i) state_next = REL;
      OWN1:    if (!m1_cyc_i) state_next = REL;
      REL:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] to_cnt_reg, to_cnt_next;
  logic        owner_stb;

  assign owner_stb = ((state_reg == OWN0) && m0_stb_i) || ((state_reg == OWN1) && m1_stb_i);
  // Owner stb gates the hit so a master that backed off never gets a phantom ack.
  assign to_hit    = owner_stb && (to_cnt_reg == TO_LIMIT);

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if ((state_next != state_reg) || s_ack_i || to_hit)
      to_cnt_next = '0;
    else if (owner_stb)
      to_cnt_next = to_cnt_reg + 16'd1;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) to_cnt_reg <= '0;
    else          to_cnt_reg <= to_cnt_next;
  end
`else
  assign to_hit = 1'b0;
`endif

  assign timeout_o = to_hit;

  // Slave signals are a pure mux of the owner; a watchdog hit masks stb and fakes the ack.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_dat_o = '0;
    grant_o  = 2'b00;
    case (state_reg)
      OWN0: begin
        grant_o  = 2'b01;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~to_hit;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i | to_hit;
        m0_dat_o = to_hit ? TIMEOUT_DATA : s_dat_i;
      end
      OWN1: begin
        grant_o  = 2'b10;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~to_hit;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i | to_hit;
        m1_dat_o = to_hit ? TIMEOUT_DATA : s_dat_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_accel_arbiter.sv
// Self-checking bench for wb_accel_arbiter: directed scenarios with randomized data,
// addresses, delays and masters, checked against a round-robin reference model.
module tb_wb_accel_arbiter;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i;
  logic        m0_ack_o;
  logic [31:0] m0_dat_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i;
  logic        m1_ack_o;
  logic [31:0] m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic        s_ack_i;
  logic [31:0] s_dat_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;
  int exp_last;  // model: index of the master granted most recently

  wb_accel_arbiter #(.TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hDEAD_BEEF)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge wb_clk_i);
  endtask

  task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  function automatic logic get_ack(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  function automatic logic [31:0] get_dat(input int m);
    return (m == 0) ? m0_dat_o : m1_dat_o;
  endfunction

  // Round-robin rule: sole requester wins; on a tie the one not granted last wins.
  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return (last == 1) ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  // One single access from IDLE: slave acks after dly stalled cycles.
  task automatic do_single(input int m, input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, input int dly, input logic [31:0] rdat);
    int w;
    logic [1:0] g;
    w = pick(m == 0, m == 1, exp_last);
    g = onehot(w);
    drive_m(m, 1'b1, 1'b1, we, sel, adr, wdat);
    smp();
    chk("pre_grant", 32'(grant_o), 32'(2'b00));
    chk("pre_stb", 32'(s_stb_o), 32'd0);
    tick();
    exp_last = w;
    for (int c = 0; c < dly; c++) begin
      smp();
      chk("wait_grant", 32'(grant_o), 32'(g));
      chk("wait_stb", 32'(s_stb_o), 32'd1);
      chk("wait_adr", s_adr_o, adr);
      chk("wait_ack", 32'(get_ack(m)), 32'd0);
      tick();
    end
    s_ack_i = 1'b1;
    s_dat_i = rdat;
    smp();
    chk("ack_grant", 32'(grant_o), 32'(g));
    chk("ack_adr", s_adr_o, adr);
    chk("ack_we", 32'(s_we_o), 32'(we));
    chk("ack_sel", 32'(s_sel_o), 32'(sel));
    chk("ack_wdat", s_dat_o, wdat);
    chk("ack_own", 32'(get_ack(m)), 32'd1);
    chk("ack_rdat", get_dat(m), rdat);
    chk("ack_other", 32'(get_ack(1 - m)), 32'd0);
    chk("dat_other", get_dat(1 - m), 32'd0);
    tick();
    drive_m(m, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    s_ack_i = 1'b0;
    s_dat_i = 32'd0;
    smp();
    chk("drop_grant", 32'(grant_o), 32'(g));
    chk("drop_cyc", 32'(s_cyc_o), 32'd0);
    tick();
    smp();
    chk("rel_grant", 32'(grant_o), 32'(2'b00));
    chk("rel_stb", 32'(s_stb_o), 32'd0);
    s_ack_i = 1'b1;
    #1;
    chk("rel_ack0", 32'(m0_ack_o), 32'd0);
    chk("rel_ack1", 32'(m1_ack_o), 32'd0);
    s_ack_i = 1'b0;
    tick();
  endtask

  initial begin
    logic [31:0] a0, a1, rd, wd;
    logic [1:0]  g;
    int          w, pulses, acked, waited;

    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    s_ack_i  = 1'b0;
    s_dat_i  = 32'd0;
    wb_rst_i = 1'b1;
    exp_last = 1;
    tick();
    smp();
    chk("rst_grant", 32'(grant_o), 32'(2'b00));
    chk("rst_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_stb", 32'(s_stb_o), 32'd0);
    chk("rst_ack0", 32'(m0_ack_o), 32'd0);
    chk("rst_ack1", 32'(m1_ack_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    tick();
    wb_rst_i = 1'b0;
    tick();

    // Directed read from m0, acked after two stalled cycles.
    do_single(0, 1'b0, 32'h3200_0004, 32'd0, 4'hF, 2, 32'h1234_5678);
    $display("single m0 read 32000004 done");

    for (int i = 0; i < 8; i++) begin
      int m;
      m = int'($urandom_range(0, 1));
      do_single(m, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(1, 15)),
                int'($urandom_range(0, 3)), $urandom);
      $display("random single %0d on m%0d done", i, m);
    end

    // Ties from a fresh reset: m0 wins first, then alternates.
    wb_rst_i = 1'b1;
    #1;
    wb_rst_i = 1'b0;
    exp_last = 1;
    tick();
    for (int r = 0; r < 3; r++) begin
      a0 = $urandom;
      a1 = $urandom;
      rd = $urandom;
      w  = pick(1'b1, 1'b1, exp_last);
      drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, a0, 32'd0);
      drive_m(1, 1'b1, 1'b1, 1'b0, 4'hF, a1, 32'd0);
      tick();
      smp();
      chk("tie_grant", 32'(grant_o), 32'((r == 1) ? 2'b10 : 2'b01));
      chk("tie_adr", s_adr_o, (w == 0) ? a0 : a1);
      s_ack_i = 1'b1;
      s_dat_i = rd;
      #1;
      chk("tie_ack_win", 32'(get_ack(w)), 32'd1);
      chk("tie_dat_win", get_dat(w), rd);
      chk("tie_ack_lose", 32'(get_ack(1 - w)), 32'd0);
      exp_last = w;
      tick();
      drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      drive_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
      s_ack_i = 1'b0;
      smp();
      chk("tie_hold", 32'(grant_o), 32'(onehot(w)));
      tick();
      smp();
      chk("tie_rel", 32'(grant_o), 32'(2'b00));
      tick();
      smp();
      chk("tie_idle", 32'(grant_o), 32'(2'b00));
      tick();
      $display("tie round %0d granted m%0d", r, w);
    end

    // m1 block write of four words while m0 waits.
    a0 = $urandom & 32'hFFFF_FFF0;
    a1 = $urandom;
    drive_m(1, 1'b1, 1'b1, 1'b1, 4'hF, a0, 32'd0);
    tick();
    smp();
    chk("blk_grant", 32'(grant_o), 32'(2'b10));
    drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, a1, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        m1_stb_i = 1'b0;
        s_ack_i  = 1'b0;
        smp();
        chk("blk_gap_grant", 32'(grant_o), 32'(2'b10));
        chk("blk_gap_stb", 32'(s_stb_o), 32'd0);
        chk("blk_gap_ack0", 32'(m0_ack_o), 32'd0);
        tick();
      end
      wd = $urandom;
      drive_m(1, 1'b1, 1'b1, 1'b1, 4'hF, a0 + 32'(4 * k), wd);
      s_ack_i = 1'b1;
      smp();
      chk("blk_adr", s_adr_o, a0 + 32'(4 * k));
      chk("blk_wdat", s_dat_o, wd);
      chk("blk_grant_k", 32'(grant_o), 32'(2'b10));
      chk("blk_ack1", 32'(m1_ack_o), 32'd1);
      chk("blk_ack0", 32'(m0_ack_o), 32'd0);
      tick();
      $display("block word %0d adr %h", k, a0 + 32'(4 * k));
    end
    s_ack_i = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    smp();
    chk("blk_tail", 32'(grant_o), 32'(2'b10));
    g = 2'b00;
    waited = 0;
    while (g != 2'b01 && waited < 6) begin
      tick();
      smp();
      g = grant_o;
      waited++;
    end
    chk("blk_m0_wait", 32'(waited), 32'd3);
    chk("blk_m0_grant", 32'(grant_o), 32'(2'b01));
    chk("blk_m0_adr", s_adr_o, a1);
    exp_last = 0;
    tick();
    s_ack_i = 1'b1;
    smp();
    chk("blk_m0_ack", 32'(m0_ack_o), 32'd1);
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();
    tick();
    tick();

    // Reset in the middle of an m0 access.
    drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, $urandom, 32'd0);
    tick();
    smp();
    chk("mid_cyc_before", 32'(s_cyc_o), 32'd1);
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("mid_cyc", 32'(s_cyc_o), 32'd0);
    chk("mid_stb", 32'(s_stb_o), 32'd0);
    chk("mid_grant", 32'(grant_o), 32'(2'b00));
    s_ack_i = 1'b1;
    #1;
    chk("mid_ack0", 32'(m0_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();
    wb_rst_i = 1'b0;
    exp_last = 1;
    tick();
    $display("reset abort done");

    // Unacknowledged access: watchdog termination or indefinite stall.
    drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, $urandom, 32'd0);
    tick();
    pulses = 0;
    acked  = 0;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 9; c++) begin
      smp();
      pulses += int'(timeout_o);
      if (c < 8) begin
        chk("to_wait_ack", 32'(m0_ack_o), 32'd0);
        chk("to_wait_stb", 32'(s_stb_o), 32'd1);
      end else begin
        chk("to_ack", 32'(m0_ack_o), 32'd1);
        chk("to_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("to_stb", 32'(s_stb_o), 32'd0);
      end
      tick();
    end
    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    for (int c = 0; c < 4; c++) begin
      smp();
      pulses += int'(timeout_o);
      tick();
    end
    chk("to_pulses", 32'(pulses), 32'd1);
    $display("watchdog termination done");
`else
    for (int c = 0; c < 100; c++) begin
      smp();
      acked  += int'(m0_ack_o);
      pulses += int'(timeout_o);
      tick();
    end
    smp();
    chk("stall_acked", 32'(acked), 32'd0);
    chk("stall_pulses", 32'(pulses), 32'd0);
    chk("stall_stb", 32'(s_stb_o), 32'd1);
    chk("stall_grant", 32'(grant_o), 32'(2'b01));
    tick();
    drive_m(0, 1'b0, 1'b0, 1'b0, 4'h0, 32'd0, 32'd0);
    tick();
    $display("stall without watchdog done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
